// File: rtl/draw_source_scheduler_pkg.sv
// Shared frame-manager definitions: bus select width and the scheduler state encoding.
`default_nettype none

package draw_source_scheduler_pkg;

    localparam int SOURCE_SEL_ADDRW = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/source_pick_lsb.sv
// Lowest-set-bit encoder: returns whether any bit is set and the index of the lowest one.
`default_nettype none

module source_pick_lsb #(
    parameter int NUM_SOURCES = 4,
    parameter int IDX_W       = 3
) (
    input  logic [NUM_SOURCES-1:0] vec,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        found = |vec;
        idx   = '0;
        // Scan downward so the last hit is the lowest set bit.
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_source_scheduler.sv
// Per-frame sequencer that grants the shared write bus to each enabled draw source in ID order.
`default_nettype none

module draw_source_scheduler
    import draw_source_scheduler_pkg::*;
#(
    parameter int NUM_SOURCES   = 4,
    parameter int IDLE_SEL      = NUM_SOURCES,
    parameter int START_TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        frame_start,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    input  logic                        err_clear,
    input  logic                        write_active,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout_err,
    output logic                        overrun_err
);

    localparam int TIMER_W = $clog2(START_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

    sched_state_t                state;
    logic [NUM_SOURCES-1:0]      pending;
    logic [SOURCE_SEL_ADDRW-1:0] idx;
    logic [TIMER_W-1:0]          timer;

    logic [NUM_SOURCES-1:0]      remaining;
    logic [NUM_SOURCES-1:0]      pick_vec;
    logic                        pick_found;
    logic [SOURCE_SEL_ADDRW-1:0] pick_idx;

    // One encoder serves both the initial pick in IDLE and the follow-on pick in NEXT.
    assign remaining = pending & ~(NUM_SOURCES'(1) << idx);
    assign pick_vec  = (state == ST_IDLE) ? source_enable : remaining;

    source_pick_lsb #(
        .NUM_SOURCES (NUM_SOURCES),
        .IDX_W       (SOURCE_SEL_ADDRW)
    ) u_pick (
        .vec   (pick_vec),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign write_source_sel = (state == ST_IDLE || state == ST_DONE)
                              ? SOURCE_SEL_ADDRW'(IDLE_SEL) : idx;
    assign write_awaited    = (state == ST_GRANT);
    assign busy             = (state != ST_IDLE);
    assign frame_done       = (state == ST_DONE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            pending     <= '0;
            idx         <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Clear wins over any same-cycle set of the sticky flags.
            if (err_clear) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end else begin
                if (frame_start && state != ST_IDLE)
                    overrun_err <= 1'b1;
                if (state == ST_WAIT && !write_active && timer == TIMER_LAST)
                    timeout_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        pending <= source_enable;
                        if (pick_found) begin
                            idx   <= pick_idx;
                            state <= ST_GRANT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_GRANT: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (write_active)
                        state <= ST_RUN;
                    else if (timer == TIMER_LAST)
                        state <= ST_NEXT;
                    else
                        timer <= timer + 1'b1;
                end
                ST_RUN: begin
                    if (!write_active)
                        state <= ST_NEXT;
                end
                ST_NEXT: begin
                    pending <= remaining;
                    if (pick_found) begin
                        idx   <= pick_idx;
                        state <= ST_GRANT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
